// File: rtl/prefetch_sched_pkg.sv
// rtl/prefetch_sched_pkg.sv - shared state encoding and burst-length helper for the read scheduler
package prefetch_sched_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

  // A requested length of zero, or one beyond the maximum, selects the maximum.
  function automatic int unsigned eff_len(input int unsigned req_len, input int unsigned max_len);
    if (req_len == 0 || req_len > max_len) return max_len;
    return req_len;
  endfunction

endpackage

// File: rtl/prefetch_rr_pick.sv
// rtl/prefetch_rr_pick.sv - combinational rotate-priority picker, ptr is the highest-priority index
module prefetch_rr_pick
  import prefetch_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  // Scan from the far end so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % N_CH);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/prefetch_fifo_rd_sched.sv
// rtl/prefetch_fifo_rd_sched.sv - round-robin burst drain of FWFT prefetch FIFOs into one registered stream
module prefetch_fifo_rd_sched
  import prefetch_sched_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = $clog2(BURST_MAX + 1),
  parameter int CH_W      = $clog2(N_CH)
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [N_CH-1:0]          ch_rd_vld,
  input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
  output logic [N_CH-1:0]          ch_rd_en,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [CNT_W-1:0]         burst_len,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     busy
);

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   gnt_inc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  cnt_inc;
  logic [N_CH-1:0]   req;
  logic              any;
  logic              load;
  logic              gnt_vld;
  logic              pop;
  logic              dry;
  logic              last_beat;
  logic [DATA_W-1:0] ch_word [N_CH];

  assign req = ch_rd_vld & ch_mask;

  prefetch_rr_pick #(
    .N_CH  (N_CH),
    .PTR_W (CH_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (win),
    .any (any)
  );

  always_comb begin
    for (int i = 0; i < N_CH; i++) ch_word[i] = ch_rd_data[i*DATA_W +: DATA_W];
  end

  assign load      = out_rdy | ~out_vld;
  assign gnt_vld   = ch_rd_vld[gnt];
  assign busy      = (state == ST_BURST);
  assign pop       = busy & load & gnt_vld;
  assign dry       = busy & load & ~gnt_vld;
  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = (cnt_inc == len);
  assign gnt_inc   = (int'(gnt) == N_CH - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    ch_rd_en = '0;
    if (pop) ch_rd_en[gnt] = 1'b1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt   <= win;
            len   <= CNT_W'(eff_len(32'(burst_len), BURST_MAX));
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        default: begin
          // Bursts end on a full-length pop or when the granted FIFO is dry while the output can load.
          if (pop) begin
            cnt <= cnt_inc;
            if (last_beat) begin
              state <= ST_IDLE;
              ptr   <= gnt_inc;
            end
          end else if (dry) begin
            state <= ST_IDLE;
            ptr   <= gnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      out_data <= '0;
      out_ch   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (pop) begin
      out_data <= ch_word[gnt];
      out_ch   <= gnt;
      out_vld  <= 1'b1;
      out_last <= last_beat;
    end else if (out_vld && out_rdy) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: doc/prefetch_fifo_rd_sched.md
# prefetch_fifo_rd_sched

Read-side scheduler that drains up to N_CH prefetch FIFOs (first-word-fall-through, rd_vld/rd_en/rd_data per channel) into one registered ready/valid stream in the rd_clk domain. Channels are served round-robin in bursts of up to a configured length. A burst ends early when the granted FIFO runs dry. The block sits between the per-channel prefetch FIFOs and the shared downstream consumer.

## Interface
- N_CH, 4, number of channels (2..8)
- DATA_W, 32, data width of every channel and of the output
- BURST_MAX, 16, largest burst length; CNT_W = $clog2(BURST_MAX+1)
- rd_clk  in  1  clock for the scheduler, all FIFO read ports and the output stream
- rd_rst  in  1  reset: asynchronous, active-high
- ch_rd_vld  in  N_CH  per-channel FIFO head valid
- ch_rd_data  in  N_CH*DATA_W  per-channel FIFO head data; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_rd_en  out  N_CH  per-channel pop; combinational, at most one bit high
- ch_mask  in  N_CH  enable per channel; 1 = eligible
- burst_len  in  CNT_W  beats per grant; 0 means BURST_MAX; values above BURST_MAX saturate to BURST_MAX
- out_data  out  DATA_W  registered output data
- out_vld  out  1  registered output valid
- out_rdy  in  1  downstream ready
- out_ch  out  $clog2(N_CH)  source channel of out_data
- out_last  out  1  marks the final beat of a full-length burst
- busy  out  1  high while in BURST

## Operation
- FSM has two states:
  - IDLE: a grant is possible when req = ch_rd_vld & ch_mask is non-zero.
  - BURST: a grant is held.
- Round-robin pick from IDLE:
  - Pointer ptr marks the highest-priority channel.
  - The winner is the first set bit of req scanning ptr, ptr+1, … with modulo-N_CH wrap.
  - On a win: latch gnt, latch len = effective burst_len, clear beat count, go to BURST.
- load = out_rdy | ~out_vld (output register free or draining).
- In BURST: ch_rd_en[gnt] = load & ch_rd_vld[gnt]. All other ch_rd_en bits are 0. All ch_rd_en bits are 0 in IDLE.
- Beat transfer (pop): out_data <= ch_rd_data[gnt], out_ch <= gnt, out_vld <= 1, cnt <= cnt+1, out_last <= (cnt+1 == len).
- A burst ends, returning to IDLE and setting ptr <= gnt+1 (mod N_CH), on either condition:
  - (a) a pop with cnt+1 == len.
  - (b) a cycle with load=1 and ch_rd_vld[gnt]=0 (dry). This ends the burst without out_last.
- While load=0 the FSM, cnt and gnt hold. A stall never ends a burst.
- Masking:
  - ch_mask is sampled only in IDLE.
  - Clearing the mask bit of the granted channel mid-burst has no effect until the burst ends.
  - burst_len is sampled only at grant.
- Output register when not popping:
  - If out_vld & out_rdy and there is no pop: out_vld <= 0, out_last <= 0.
  - out_data and out_ch hold.
- rd_rst mid-burst forces:
  - IDLE; ptr=0, gnt=0, cnt=0.
  - Output register cleared; any beat held in it is discarded. The FIFOs keep their contents.

## Timing
- Reset values: out_vld=0, out_data=0, out_ch=0, out_last=0, busy=0, ch_rd_en=0. ptr=0, so channel 0 has priority.
- Latency: ch_rd_vld rises in IDLE at cycle t → grant at t+1 (busy=1, first pop) → out_vld=1 at t+2.
- Throughput is 1 beat/cycle inside a burst with out_rdy held high.
- There is exactly one IDLE cycle between consecutive bursts.
- Pop and FIFO data are same-cycle, consistent with first-word-fall-through semantics. Data is captured on the edge where ch_rd_en is high.
- out_last is high together with out_vld and only for that beat. It clears on handshake unless the next pop also sets it.

## Structure
- Package prefetch_sched_pkg:
  - FSM state enum (ST_IDLE, ST_BURST).
  - Function for effective-length conversion (0/overflow → BURST_MAX).
- Sub-module prefetch_rr_pick:
  - Purely combinational rotate-priority encoder.
  - Inputs: req and ptr. Outputs: winner index and any.
  - Reused by other arbiters in the design.
- Top: FSM, counter, pointer, output register and ch_rd_en decode.

## Test plan
- Reset: assert rd_rst with all ch_rd_vld=1 → all outputs 0. After release, first grant is ch0 at the first rd_clk edge and out_vld rises 2 cycles after release.
- Round-robin: N_CH=4, all channels hold 8 words, burst_len=4, out_rdy=1 → out_ch sequence is 0×4, 1×4, 2×4, 3×4, 0×4…, out_last on every 4th beat, one bubble between bursts.
- Dry channel: ch1 holds 2 words, burst_len=4 → 2 beats from ch1 with no out_last, then ch2 is granted. ptr advances past ch1.
- Backpressure: out_rdy toggles 1/0 every cycle during a 4-beat burst → no ch_rd_en while load=0, data order preserved, no beat lost or duplicated, out_last on beat 4.
- Mask and burst_len edge cases: ch_mask=4'b0101 with all valid → only ch0 and ch2 alternate. burst_len=0 → bursts of 16. burst_len=31 → bursts of 16. Clearing ch_mask[gnt] mid-burst → burst completes.
- Mid-burst reset: rd_rst for 1 cycle at beat 2 → out_vld=0, busy=0, ch_rd_en=0 immediately. The next grant goes to ch0.
